// File: rtl/digital_pd_pkg.sv
// Shared types, error range and saturation helper for the digital_pd
// counter-based phase/frequency detector.
package digital_pd_pkg;

  localparam int ERR_W   = 4;
  localparam int ERR_MIN = -8;
  localparam int ERR_MAX = 7;

  typedef enum logic {
    IDLE,
    MEASURE
  } pd_state_e;

  // Callers sign-extend their CNT_W+1 bit difference to 32 bits before calling.
  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [31:0] diff);
    logic signed [ERR_W-1:0] res;
    if (diff > ERR_MAX) begin
      res = ERR_W'(ERR_MAX);
    end else if (diff < ERR_MIN) begin
      res = ERR_W'(ERR_MIN);
    end else begin
      res = diff[ERR_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/digital_pd_edge_sync.sv
// Two-flop synchronizer plus a delay flop that turns an asynchronous
// input into a single-cycle rising-edge pulse in the clk domain.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync2_q, sync3_q;
  logic sync1_d, sync2_d, sync3_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/digital_pd.sv
// Counter-based digital phase/frequency detector: measures the reference period
// in clk cycles and reports a saturated error against fcw. Optional lock
// detector enabled with `define DIGITAL_PD_LOCK_DET_EN.
module digital_pd
  import digital_pd_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int LOCK_TOL = 1,
  parameter int LOCK_CNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              ref_in,
  input  logic [CNT_W-1:0]  fcw,
  output logic signed [3:0] err,
  output logic              err_valid,
  output logic              ref_lost,
  output logic              locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pd_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic                    err_valid_q, err_valid_d;
  logic                    ref_lost_q, ref_lost_d;
  logic                    timeout;
  logic                    rise;
  logic signed [CNT_W:0]   diff;

  edge_sync u_ref_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ref_in),
    .rise  (rise)
  );

  assign diff = $signed({1'b0, fcw}) - $signed({1'b0, cnt_q});

  // A rise in the same cycle as the terminal count is a normal measurement.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    ref_lost_d  = ref_lost_q;
    timeout     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d    = MEASURE;
            cnt_d      = CNT_W'(1);
            ref_lost_d = 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            err_d       = sat_err(32'(diff));
            err_valid_d = 1'b1;
            cnt_d       = CNT_W'(1);
          end else if (cnt_q == CNT_MAX) begin
            timeout     = 1'b1;
            err_d       = ERR_W'(ERR_MIN);
            err_valid_d = 1'b1;
            ref_lost_d  = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      ref_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      ref_lost_q  <= ref_lost_d;
    end
  end

  assign err       = err_q;
  assign err_valid = err_valid_q;
  assign ref_lost  = ref_lost_q;

`ifdef DIGITAL_PD_LOCK_DET_EN
  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  logic [RUN_W-1:0] lock_run_q, lock_run_d;
  logic             locked_q, locked_d;
  logic [ERR_W:0]   err_abs;

  // Lock is judged on the error being emitted this cycle so it lines up with err_valid.
  always_comb begin
    lock_run_d = lock_run_q;
    err_abs    = err_d[ERR_W-1] ? -{err_d[ERR_W-1], err_d} : {1'b0, err_d};
    if (!en || timeout) begin
      lock_run_d = '0;
    end else if (err_valid_d) begin
      if (int'(err_abs) <= LOCK_TOL) begin
        lock_run_d = (lock_run_q == RUN_W'(LOCK_CNT)) ? lock_run_q : lock_run_q + RUN_W'(1);
      end else begin
        lock_run_d = '0;
      end
    end
    locked_d = (lock_run_d == RUN_W'(LOCK_CNT));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_run_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_run_q <= lock_run_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  logic unused_lock;
  assign unused_lock = ^{timeout, LOCK_TOL, LOCK_CNT};
  assign locked      = 1'b0;
`endif

endmodule
